// File: rtl/rr_grant_scheduler_pkg.sv
// rtl/rr_grant_scheduler_pkg.sv - shared types and sizes for the round-robin grant scheduler
//
// Purpose: state encoding and requester sizing shared by the scheduler top
//          and its grant decoder.
// Ports:   none (package).
package rr_grant_scheduler_pkg;

  // Number of requesters and width of a requester index.
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  // Scheduler state. The encoding is fixed so the registered state can be
  // probed directly: IDLE=0, GRANT=1.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage : rr_grant_scheduler_pkg

// File: rtl/rr_grant_scheduler_decoder.sv
// rtl/rr_grant_scheduler_decoder.sv - 3-to-8 enabled one-hot decoder
//
// Purpose: drives exactly one output bit, selected by a, while e is high;
//          all outputs are low while e is low.
// Ports:
//   a  in   [IDX_W-1:0]    binary select
//   e  in   1              enable
//   D  out  [NUM_REQ-1:0]  one-hot decode of a when e=1, else zero
module decoder
  import rr_grant_scheduler_pkg::*;
(
  input  logic [IDX_W-1:0]   a,
  input  logic               e,
  output logic [NUM_REQ-1:0] D
);

  always_comb begin
    D = '0;
    if (e) begin
      D[a] = 1'b1;
    end
  end

endmodule : decoder

// File: rtl/rr_grant_scheduler.sv
// rtl/rr_grant_scheduler.sv - round-robin arbiter with bounded grant hold time
//
// Purpose: grants a shared resource to one of eight requesters in round-robin
//          order. A grant lasts while the owner keeps its request high, up to
//          MAX_HOLD cycles, after which it is force-released with a one-cycle
//          timeout pulse. Every release is followed by at least one idle cycle.
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles (1..255)
//   CNT_W     hold-counter width, 2**CNT_W must exceed MAX_HOLD
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  request vector, held until served
//   gnt        out  8  one-hot grant, zero when no grant is active
//   gnt_idx    out  3  index of the current or most recent grantee
//   gnt_valid  out  1  grant active (equals |gnt)
//   timeout    out  1  one-cycle pulse after a forced release
module rr_grant_scheduler
  import rr_grant_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  // Counter value on the last permitted grant cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [IDX_W-1:0]   win_idx;

  // Round-robin search: first set request at or above ptr, wrapping 7->0.
  // Scanning offsets from highest to lowest lets the smallest matching offset
  // win by being assigned last. The result is only used when |req.
  always_comb begin
    win_idx = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr_q + IDX_W'(i)]) begin
        win_idx = ptr_q + IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = win_idx;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        if (!req[idx_q]) begin
          // Owner finished: voluntary release, no timeout.
          state_d = IDLE;
          ptr_d   = idx_q + 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          // Owner used its full allowance: force release and flag it.
          state_d   = IDLE;
          ptr_d     = idx_q + 1'b1;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Grant is decoded purely from registered state, so req never reaches gnt
  // combinationally and reset clears it without waiting for a clock.
  decoder u_decoder (
    .a (idx_q),
    .e (state_q == GRANT),
    .D (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt;
  assign timeout   = timeout_q;

endmodule : rr_grant_scheduler
